hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Parametrised hazard unit for the 5-stage pipeline. It covers branch flush and load-use stall, and adds two things the previous unit lacked: a multi-cycle stall sequencer for multiply ops of configurable latency, and $zero filtering.
- Sits beside the ID stage and drives PC, IF/ID and ID/EX/EX/MEM write/flush controls.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- BR_W, 2, width of the branch-taken code; any nonzero value means redirect.
- MUL_LAT, 3, EX-stage cycles a multiply needs before its result can be forwarded; legal range 1..15.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
- Branch  input  BR_W  nonzero = taken branch/jump resolved this cycle.
- IDEX_MemRead  input  1  instruction in ID/EX is a load.
- IDEX_RegWrite  input  1  instruction in ID/EX writes a register.
- IDEX_MulOp  input  1  instruction in ID/EX is a multiply.
- IDEX_Rd  input  REG_ADDR_W  destination of the ID/EX R-type/multiply.
- IDEX_Rt  input  REG_ADDR_W  destination of the ID/EX load.
- IFID_Rs  input  REG_ADDR_W  source 1 of the IF/ID instruction.
- IFID_Rt  input  REG_ADDR_W  source 2 of the IF/ID instruction.
- IFID_UsesRt  input  1  IF/ID instruction actually reads Rt.
- IFID_Flush  output  1  clear IF/ID.
- IDEX_Flush  output  1  insert bubble into ID/EX.
- EXMEM_Flush  output  1  clear EX/MEM.
- IFID_Write  output  1  IF/ID load enable.
- PC_Write  output  1  PC load enable.
- Busy  output  1  high while in MUL_STALL.
- StallCycles  output  CNT_W  saturating count of cycles with PC_Write=0.

Behaviour:
- Match terms, with register 0 never matching:
  - src_hit(r) = (r!=0) & ((r==IFID_Rs) | (IFID_UsesRt & r==IFID_Rt)).
  - load_haz = IDEX_MemRead & src_hit(IDEX_Rt).
  - mul_haz = IDEX_RegWrite & IDEX_MulOp & src_hit(IDEX_Rd).
- State machine: RUN and MUL_STALL, plus a 4-bit down-counter Rem.
- Outputs are combinational from state and inputs. Default output values: flushes 0, IFID_Write=1, PC_Write=1.
- Priority 1, Branch!=0 (any state):
  - IFID_Flush = IDEX_Flush = EXMEM_Flush = 1; PC_Write = IFID_Write = 1.
  - Next state RUN, Rem=0. A branch aborts any stall in progress.
- Priority 2, RUN with mul_haz:
  - IDEX_Flush=1, IFID_Write=0, PC_Write=0.
  - If MUL_LAT==1, stay in RUN. Otherwise Rem<=MUL_LAT-1 and go to MUL_STALL.
- Priority 3, RUN with load_haz: IDEX_Flush=1, IFID_Write=0, PC_Write=0 for exactly one cycle; stay in RUN. mul_haz takes precedence if both are true.
- MUL_STALL:
  - IDEX_Flush=1, IFID_Write=0, PC_Write=0, regardless of the hazard inputs (ID/EX holds a bubble).
  - Rem decrements each cycle; when Rem==1, next state is RUN.
  - Total consecutive stall cycles for one multiply hazard = MUL_LAT.
- After a stall ends, RUN re-evaluates the hazard inputs on the next cycle. The bubble now in ID/EX normally clears the hazard.
- StallCycles increments on each clock with PC_Write=0 and Rst_n=1; it holds at 2^CNT_W-1.
- Busy = (state==MUL_STALL).
- Reset, while Rst_n=0 at an edge: state RUN, Rem=0, StallCycles=0.
  - While Rst_n is low, outputs are forced to flushes 0, IFID_Write=1, PC_Write=1, Busy=0.
  - Reset in the middle of MUL_STALL aborts the stall at that edge.
- MUL_LAT outside 1..15 is a configuration error; flag it with an elaboration-time check.

Test Plan:
- Rst_n=0 for 2 cycles, then release with all inputs 0 -> flushes 0, PC_Write=1, IFID_Write=1, StallCycles=0, Busy=0.
- Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 for one cycle, then IDEX_MemRead=0 -> exactly one cycle of PC_Write=0, IFID_Write=0, IDEX_Flush=1; StallCycles=1.
- Multiply with MUL_LAT=3: IDEX_MulOp=1, IDEX_RegWrite=1, IDEX_Rd=9, IFID_Rt=9, IFID_UsesRt=1 for one cycle -> PC_Write low 3 consecutive cycles, Busy high on cycles 2-3, StallCycles=3. Same stimulus with IFID_UsesRt=0 -> no stall.
- $zero filter: load with IDEX_Rt=0, IFID_Rs=0 -> no stall. Branch=2'b01 in RUN -> all three flushes high for that cycle, PC_Write=1.
- Branch=2'b10 on the 2nd cycle of a MUL_LAT=3 stall -> flushes high, PC_Write=1 that cycle; next cycle RUN, Busy=0; StallCycles=1.
- Rst_n=0 during MUL_STALL -> next cycle RUN, outputs at reset values. CNT_W=4 with 20 forced stall cycles -> StallCycles saturates at 15.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Hazard control unit for the 5-stage pipeline.
// Handles branch flush, load-use stall, and multi-cycle multiply stalls.
// Register 0 never creates a hazard.
// A saturating counter records how many cycles the PC was held.
module hazard_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int BR_W       = 2,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [BR_W-1:0]       Branch,
    input  logic                  IDEX_MemRead,
    input  logic                  IDEX_RegWrite,
    input  logic                  IDEX_MulOp,
    input  logic [REG_ADDR_W-1:0] IDEX_Rd,
    input  logic [REG_ADDR_W-1:0] IDEX_Rt,
    input  logic [REG_ADDR_W-1:0] IFID_Rs,
    input  logic [REG_ADDR_W-1:0] IFID_Rt,
    input  logic                  IFID_UsesRt,
    output logic                  IFID_Flush,
    output logic                  IDEX_Flush,
    output logic                  EXMEM_Flush,
    output logic                  IFID_Write,
    output logic                  PC_Write,
    output logic                  Busy,
    output logic [CNT_W-1:0]      StallCycles
);

    // The remaining-cycle counter is 4 bits wide, so the multiply latency must fit in it.
    generate
        if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
            $error("hazard_control_unit: MUL_LAT must be in the range 1..15");
        end
    endgenerate

    typedef enum logic {
        RUN       = 1'b0,
        MUL_STALL = 1'b1
    } state_t;

    localparam logic [3:0]       REM_INIT = 4'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t     state;
    state_t     next_state;
    logic [3:0] rem;
    logic [3:0] next_rem;

    logic load_hit;
    logic mul_hit;
    logic load_haz;
    logic mul_haz;
    logic branch_taken;

    // Source-match terms for the two hazard kinds, with register 0 masked out.
    always_comb begin
        load_hit = (IDEX_Rt != '0) &&
                   ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
        mul_hit  = (IDEX_Rd != '0) &&
                   ((IDEX_Rd == IFID_Rs) || (IFID_UsesRt && (IDEX_Rd == IFID_Rt)));
        load_haz     = IDEX_MemRead && load_hit;
        mul_haz      = IDEX_RegWrite && IDEX_MulOp && mul_hit;
        branch_taken = |Branch;
    end

    // State and remaining-cycle registers; reset aborts any stall in progress.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= RUN;
            rem   <= 4'd0;
        end else begin
            state <= next_state;
            rem   <= next_rem;
        end
    end

    // Next state and pipeline controls.
    // Priority: branch first, then multiply hazard, then load hazard.
    always_comb begin
        next_state  = state;
        next_rem    = rem;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        IFID_Write  = 1'b1;
        PC_Write    = 1'b1;
        Busy        = 1'b0;
        if (Rst_n) begin
            Busy = (state == MUL_STALL);
            if (branch_taken) begin
                IFID_Flush  = 1'b1;
                IDEX_Flush  = 1'b1;
                EXMEM_Flush = 1'b1;
                next_state  = RUN;
                next_rem    = 4'd0;
            end else begin
                case (state)
                    RUN: begin
                        if (mul_haz) begin
                            IDEX_Flush = 1'b1;
                            IFID_Write = 1'b0;
                            PC_Write   = 1'b0;
                            if (MUL_LAT > 1) begin
                                next_rem   = REM_INIT;
                                next_state = MUL_STALL;
                            end
                        end else if (load_haz) begin
                            IDEX_Flush = 1'b1;
                            IFID_Write = 1'b0;
                            PC_Write   = 1'b0;
                        end
                    end
                    MUL_STALL: begin
                        IDEX_Flush = 1'b1;
                        IFID_Write = 1'b0;
                        PC_Write   = 1'b0;
                        next_rem   = rem - 4'd1;
                        if (rem <= 4'd1) begin
                            next_state = RUN;
                            next_rem   = 4'd0;
                        end
                    end
                    default: begin
                        next_state = RUN;
                        next_rem   = 4'd0;
                    end
                endcase
            end
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            StallCycles <= '0;
        end else if (!PC_Write && (StallCycles != CNT_MAX)) begin
            StallCycles <= StallCycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed, table-driven bench for hazard_control_unit.
// A second instance with a 4-bit counter shares all inputs.
// That instance is used to check counter saturation.
module tb_hazard_control_unit;

    logic        Clk;
    logic        Rst_n;
    logic [1:0]  Branch;
    logic        IDEX_MemRead;
    logic        IDEX_RegWrite;
    logic        IDEX_MulOp;
    logic [4:0]  IDEX_Rd;
    logic [4:0]  IDEX_Rt;
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic        IFID_UsesRt;

    logic        IFID_Flush, IDEX_Flush, EXMEM_Flush, IFID_Write, PC_Write, Busy;
    logic [15:0] StallCycles;
    logic        s_IFID_Flush, s_IDEX_Flush, s_EXMEM_Flush, s_IFID_Write, s_PC_Write, s_Busy;
    logic [3:0]  s_StallCycles;

    int nCompared = 0;
    int nFailed   = 0;

    hazard_control_unit #(.REG_ADDR_W(5), .BR_W(2), .MUL_LAT(3), .CNT_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Branch(Branch),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MulOp(IDEX_MulOp),
        .IDEX_Rd(IDEX_Rd), .IDEX_Rt(IDEX_Rt), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
        .IFID_Write(IFID_Write), .PC_Write(PC_Write), .Busy(Busy), .StallCycles(StallCycles)
    );

    hazard_control_unit #(.REG_ADDR_W(5), .BR_W(2), .MUL_LAT(3), .CNT_W(4)) dut_small (
        .Clk(Clk), .Rst_n(Rst_n), .Branch(Branch),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MulOp(IDEX_MulOp),
        .IDEX_Rd(IDEX_Rd), .IDEX_Rt(IDEX_Rt), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt),
        .IFID_Flush(s_IFID_Flush), .IDEX_Flush(s_IDEX_Flush), .EXMEM_Flush(s_EXMEM_Flush),
        .IFID_Write(s_IFID_Write), .PC_Write(s_PC_Write), .Busy(s_Busy),
        .StallCycles(s_StallCycles)
    );

    // Clock starts high so the first check (a falling edge) precedes the first rising edge.
    initial begin
        Clk = 1'b1;
        forever #5 Clk = ~Clk;
    end

    // exp bit order: {IFID_Flush, IDEX_Flush, EXMEM_Flush, IFID_Write, PC_Write, Busy}
    typedef struct {
        logic        rst_n;
        logic [1:0]  br;
        logic        mr;
        logic        rw;
        logic        mo;
        logic [4:0]  rd;
        logic [4:0]  rte;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        ur;
        logic [5:0]  exp;
        logic        chk;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] O_IDLE  = 6'b000110;
    localparam logic [5:0] O_STALL = 6'b010000;
    localparam logic [5:0] O_MULST = 6'b010001;
    localparam logic [5:0] O_BR    = 6'b111110;
    localparam logic [5:0] O_BRBSY = 6'b111111;

    task automatic applyStimulus(input vec_t v);
        Rst_n         = v.rst_n;
        Branch        = v.br;
        IDEX_MemRead  = v.mr;
        IDEX_RegWrite = v.rw;
        IDEX_MulOp    = v.mo;
        IDEX_Rd       = v.rd;
        IDEX_Rt       = v.rte;
        IFID_Rs       = v.rs;
        IFID_Rt       = v.rt;
        IFID_UsesRt   = v.ur;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [5:0] exp, input logic chk,
                            input logic [15:0] cnt);
        logic [15:0] sat;
        checkOutput({tag, " outputs"},
                    {26'd0, IFID_Flush, IDEX_Flush, EXMEM_Flush, IFID_Write, PC_Write, Busy},
                    {26'd0, exp});
        checkOutput({tag, " small outputs"},
                    {26'd0, s_IFID_Flush, s_IDEX_Flush, s_EXMEM_Flush, s_IFID_Write,
                     s_PC_Write, s_Busy},
                    {26'd0, exp});
        if (chk) begin
            sat = (cnt > 16'd15) ? 16'd15 : cnt;
            checkOutput({tag, " StallCycles"}, {16'd0, StallCycles}, {16'd0, cnt});
            checkOutput({tag, " small StallCycles"}, {28'd0, s_StallCycles}, {16'd0, sat});
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        applyStimulus(v);
        @(negedge Clk);
        checkAll(tag, v.exp, v.chk, v.cnt);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // rst br mr rw mo rd rte rs rt ur exp chk cnt
        vecs.push_back('{1'b0, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b0, 16'd0});
        vecs.push_back('{1'b0, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd0});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd0});
        vecs.push_back('{1'b1, 2'b00, 1, 0, 0, 5'd0, 5'd8, 5'd8, 5'd0, 0, O_STALL, 1'b1, 16'd0});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd8, 5'd8, 5'd0, 0, O_IDLE,  1'b1, 16'd1});
        vecs.push_back('{1'b1, 2'b00, 0, 1, 1, 5'd9, 5'd0, 5'd0, 5'd9, 1, O_STALL, 1'b1, 16'd1});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_MULST, 1'b1, 16'd2});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_MULST, 1'b1, 16'd3});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd4});
        vecs.push_back('{1'b1, 2'b00, 0, 1, 1, 5'd9, 5'd0, 5'd0, 5'd9, 0, O_IDLE,  1'b1, 16'd4});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd4});
        vecs.push_back('{1'b1, 2'b00, 1, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd4});
        vecs.push_back('{1'b1, 2'b01, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_BR,    1'b1, 16'd4});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd4});
        vecs.push_back('{1'b1, 2'b00, 0, 1, 1, 5'd9, 5'd0, 5'd0, 5'd9, 1, O_STALL, 1'b1, 16'd4});
        vecs.push_back('{1'b1, 2'b10, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_BRBSY, 1'b1, 16'd5});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd5});
        vecs.push_back('{1'b1, 2'b00, 0, 1, 1, 5'd9, 5'd0, 5'd0, 5'd9, 1, O_STALL, 1'b1, 16'd5});
        vecs.push_back('{1'b0, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd6});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd0});
        vecs.push_back('{1'b1, 2'b00, 1, 1, 1, 5'd7, 5'd5, 5'd7, 5'd0, 0, O_STALL, 1'b1, 16'd0});
        vecs.push_back('{1'b1, 2'b00, 1, 0, 0, 5'd0, 5'd5, 5'd5, 5'd0, 0, O_MULST, 1'b1, 16'd1});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_MULST, 1'b1, 16'd2});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd3});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 1, 5'd9, 5'd0, 5'd9, 5'd0, 0, O_IDLE,  1'b1, 16'd3});
        vecs.push_back('{1'b1, 2'b00, 0, 1, 1, 5'd0, 5'd0, 5'd0, 5'd0, 1, O_IDLE,  1'b1, 16'd3});
        vecs.push_back('{1'b1, 2'b00, 1, 0, 0, 5'd0, 5'd12, 5'd0, 5'd12, 0, O_IDLE, 1'b1, 16'd3});
        vecs.push_back('{1'b1, 2'b00, 1, 0, 0, 5'd0, 5'd12, 5'd0, 5'd12, 1, O_STALL, 1'b1, 16'd3});
        vecs.push_back('{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE,  1'b1, 16'd4});

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // A persistent load hazard stalls every cycle.
        // Run it for 20 cycles: the 4-bit counter must saturate at 15.
        v = '{1'b1, 2'b00, 1, 0, 0, 5'd0, 5'd3, 5'd3, 5'd0, 0, O_STALL, 1'b1, 16'd4};
        for (int i = 0; i < 20; i++) begin
            v.cnt = 16'(4 + i);
            step($sformatf("sat%0d", i), v);
        end
        v = '{1'b1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, O_IDLE, 1'b1, 16'd24};
        step("sat_end", v);
        step("sat_hold", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
